// File: rtl/data_mem_arbiter_pkg.sv
// Shared constants for the data RAM arbiter: response-state encoding and port indices.
package data_mem_arbiter_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
    localparam logic [STATE_W-1:0] ST_RD0  = 3'd1;
    localparam logic [STATE_W-1:0] ST_RD1  = 3'd2;
    localparam logic [STATE_W-1:0] ST_ERR0 = 3'd3;
    localparam logic [STATE_W-1:0] ST_ERR1 = 3'd4;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data RAM with 1-cycle read latency.
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int unsigned MEM   = 17,
    parameter int unsigned DEPTH = 3 << (MEM - 2)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [MEM-1:0]    p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [MEM-1:0]    p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p0_gnt,
    output logic              p1_gnt,
    output logic              p0_rvalid,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p0_err,
    output logic              p1_err,
    output logic              ram_we,
    output logic [MEM-1:0]    ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    logic [STATE_W-1:0] state_q, state_d;
    logic               last_q, last_d;
    logic [DATA_W-1:0]  rdata0_q, rdata0_d;
    logic [DATA_W-1:0]  rdata1_q, rdata1_d;

    logic              p0_sel, p1_sel, grant_any, gnt_port;
    logic              sel_we, in_range;
    logic [MEM-1:0]    sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Arbitration, RAM drive and next-state all come from one decision.
    always_comb begin
        p0_sel    = 1'b0;
        p1_sel    = 1'b0;
        state_d   = ST_IDLE;
        last_d    = last_q;
        if (!rst) begin
            p0_sel = p0_req && (!p1_req || (last_q == PORT1));
            p1_sel = p1_req && !p0_sel;
        end
        grant_any = p0_sel || p1_sel;
        gnt_port  = p1_sel ? PORT1 : PORT0;
        sel_we    = p1_sel ? p1_we    : p0_we;
        sel_addr  = p1_sel ? p1_addr  : p0_addr;
        sel_wdata = p1_sel ? p1_wdata : p0_wdata;
        in_range  = 32'(sel_addr) < 32'(DEPTH);

        p0_gnt   = p0_sel;
        p1_gnt   = p1_sel;
        ram_we   = grant_any && in_range && sel_we;
        ram_addr = grant_any ? sel_addr  : '0;
        ram_din  = grant_any ? sel_wdata : '0;

        if (grant_any) begin
            if (!in_range) begin
                state_d = (gnt_port == PORT1) ? ST_ERR1 : ST_ERR0;
            end else begin
                last_d = gnt_port;
                if (!sel_we) begin
                    state_d = (gnt_port == PORT1) ? ST_RD1 : ST_RD0;
                end
            end
        end

        // Responses for last cycle's access; reset squashes anything in flight.
        p0_rvalid = !rst && (state_q == ST_RD0);
        p1_rvalid = !rst && (state_q == ST_RD1);
        p0_err    = !rst && (state_q == ST_ERR0);
        p1_err    = !rst && (state_q == ST_ERR1);

        rdata0_d = p0_rvalid ? ram_dout : rdata0_q;
        rdata1_d = p1_rvalid ? ram_dout : rdata1_q;
        p0_rdata = rst ? '0 : rdata0_d;
        p1_rdata = rst ? '0 : rdata1_d;
    end

    // Pointer resets to port 1 so port 0 wins the first conflict.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            last_q   <= PORT1;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed self-checking bench for data_mem_arbiter with a behavioural 1-cycle RAM.
module tb_data_mem_arbiter;

    localparam int unsigned MEM   = 17;
    localparam int unsigned DEPTH = 3 << (MEM - 2);

    logic clk = 1'b0;
    logic rst;
    logic p0_req, p0_we, p1_req, p1_we;
    logic [MEM-1:0] p0_addr, p1_addr;
    logic [31:0] p0_wdata, p1_wdata;
    logic p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic ram_we;
    logic [MEM-1:0] ram_addr;
    logic [31:0] ram_din, ram_dout;

    logic [31:0] mem [0:(1<<MEM)-1];

    int checks = 0;
    int errors = 0;

    data_mem_arbiter #(.MEM(MEM), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p0_gnt(p0_gnt), .p1_gnt(p1_gnt),
        .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
        .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
        .p0_err(p0_err), .p1_err(p1_err),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    function automatic logic [31:0] exp_word(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h111;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_p0(input logic req, input logic we, input logic [MEM-1:0] addr, input logic [31:0] wd);
        p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wd;
    endtask

    task automatic set_p1(input logic req, input logic we, input logic [MEM-1:0] addr, input logic [31:0] wd);
        p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wd;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_p0(1'b0, 1'b0, '0, '0);
        set_p1(1'b0, 1'b0, '0, '0);
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_p0(1'b1, 1'b1, 17'h3, 32'h55);
        set_p1(1'b1, 1'b1, 17'h4, 32'h66);
        next_cycle();
        next_cycle();
        checks++;
        if ({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err, ram_we} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 0000000",
                     {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err, ram_we});
        end
        checks++;
        if (p0_rdata !== 32'h0 || p1_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata: got %h/%h required 0/0", p0_rdata, p1_rdata);
        end
        do_reset();
    endtask

    task automatic test_store_load();
        set_p0(1'b1, 1'b1, 17'h10, 32'hDEADBEEF);
        #1;
        checks++;
        if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0 || ram_we !== 1'b1 || ram_addr !== 17'h10 || ram_din !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL st_drive: gnt=%b%b we=%b addr=%h din=%h required 10 1 10 deadbeef",
                     p0_gnt, p1_gnt, ram_we, ram_addr, ram_din);
        end
        next_cycle();
        set_p0(1'b1, 1'b0, 17'h10, 32'h0);
        #1;
        checks++;
        if (p0_gnt !== 1'b1 || ram_we !== 1'b0 || p0_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL ld_gnt: gnt=%b we=%b rvalid=%b required 1 0 0", p0_gnt, ram_we, p0_rvalid);
        end
        next_cycle();
        set_p0(1'b0, 1'b0, '0, '0);
        checks++;
        if (p0_rvalid !== 1'b1 || p0_rdata !== 32'hDEADBEEF || p1_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL ld_data: rvalid=%b rdata=%h required 1 deadbeef", p0_rvalid, p0_rdata);
        end
        next_cycle();
        checks++;
        if (p0_rvalid !== 1'b0 || p0_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL ld_hold: rvalid=%b rdata=%h required 0 deadbeef", p0_rvalid, p0_rdata);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_gnt;
        do_reset();
        set_p0(1'b1, 1'b0, 17'h1, '0);
        set_p1(1'b1, 1'b0, 17'h2, '0);
        for (int k = 0; k <= 4; k++) begin
            if (k == 4) begin
                set_p0(1'b0, 1'b0, '0, '0);
                set_p1(1'b0, 1'b0, '0, '0);
            end
            #1;
            if (k < 4) begin
                exp_gnt = (k % 2 == 0) ? 2'b10 : 2'b01;
                checks++;
                if ({p0_gnt, p1_gnt} !== exp_gnt) begin
                    errors++;
                    $display("FAIL rr_gnt[%0d]: got %b required %b", k, {p0_gnt, p1_gnt}, exp_gnt);
                end
            end
            if (k > 0) begin
                checks++;
                if ((k - 1) % 2 == 0) begin
                    if (p0_rvalid !== 1'b1 || p1_rvalid !== 1'b0 || p0_rdata !== exp_word(1)) begin
                        errors++;
                        $display("FAIL rr_resp[%0d]: rv=%b%b rdata=%h required 10 %h",
                                 k, p0_rvalid, p1_rvalid, p0_rdata, exp_word(1));
                    end
                end else begin
                    if (p1_rvalid !== 1'b1 || p0_rvalid !== 1'b0 || p1_rdata !== exp_word(2) || p0_rdata !== exp_word(1)) begin
                        errors++;
                        $display("FAIL rr_resp[%0d]: rv=%b%b rdata=%h/%h required 01 %h/%h",
                                 k, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata, exp_word(1), exp_word(2));
                    end
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_out_of_range();
        set_p1(1'b1, 1'b0, 17'(DEPTH), '0);
        #1;
        checks++;
        if (p1_gnt !== 1'b1 || p0_gnt !== 1'b0 || ram_we !== 1'b0) begin
            errors++;
            $display("FAIL oor_ld_gnt: gnt=%b%b we=%b required 01 0", p0_gnt, p1_gnt, ram_we);
        end
        next_cycle();
        set_p1(1'b0, 1'b0, '0, '0);
        set_p0(1'b1, 1'b1, 17'h1FFFF, 32'hBAD0BAD0);
        #1;
        checks++;
        if (p1_err !== 1'b1 || p1_rvalid !== 1'b0 || p0_err !== 1'b0) begin
            errors++;
            $display("FAIL oor_ld_err: err=%b%b rvalid=%b required 01 0", p0_err, p1_err, p1_rvalid);
        end
        checks++;
        if (p0_gnt !== 1'b1 || ram_we !== 1'b0) begin
            errors++;
            $display("FAIL oor_st_gnt: gnt=%b we=%b required 1 0", p0_gnt, ram_we);
        end
        next_cycle();
        set_p0(1'b1, 1'b0, 17'h3, '0);
        set_p1(1'b1, 1'b0, 17'h4, '0);
        #1;
        checks++;
        if (p0_err !== 1'b1 || p1_err !== 1'b0 || p0_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL oor_st_err: err=%b%b rvalid=%b required 10 0", p0_err, p1_err, p0_rvalid);
        end
        checks++;
        if ({p0_gnt, p1_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL oor_ptr: gnt=%b required 10", {p0_gnt, p1_gnt});
        end
        next_cycle();
        set_p0(1'b0, 1'b0, '0, '0);
        set_p1(1'b0, 1'b0, '0, '0);
        next_cycle();
        next_cycle();
    endtask

    task automatic test_reset_mid();
        set_p0(1'b1, 1'b0, 17'h3, '0);
        #1;
        checks++;
        if (p0_gnt !== 1'b1) begin
            errors++;
            $display("FAIL rm_gnt: got %b required 1", p0_gnt);
        end
        next_cycle();
        rst = 1'b1;
        set_p1(1'b1, 1'b0, 17'h4, '0);
        #1;
        checks++;
        if ({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err, ram_we} !== 7'b0 ||
            p0_rdata !== 32'h0 || p1_rdata !== 32'h0) begin
            errors++;
            $display("FAIL rm_squash: ctrl=%b rdata=%h/%h required 0000000 0/0",
                     {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err, ram_we}, p0_rdata, p1_rdata);
        end
        next_cycle();
        rst = 1'b0;
        #1;
        checks++;
        if ({p0_gnt, p1_gnt} !== 2'b10 || p0_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rm_after: gnt=%b rvalid=%b required 10 0", {p0_gnt, p1_gnt}, p0_rvalid);
        end
        set_p0(1'b0, 1'b0, '0, '0);
        set_p1(1'b0, 1'b0, '0, '0);
        next_cycle();
        next_cycle();
    endtask

    task automatic test_stream();
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) set_p0(1'b1, 1'b0, 17'(i), '0);
            else       set_p0(1'b0, 1'b0, '0, '0);
            #1;
            if (i < 8) begin
                checks++;
                if (p0_gnt !== 1'b1 || ram_addr !== 17'(i)) begin
                    errors++;
                    $display("FAIL stream_gnt[%0d]: gnt=%b addr=%h required 1 %h", i, p0_gnt, ram_addr, 17'(i));
                end
            end
            if (i > 0) begin
                checks++;
                if (p0_rvalid !== 1'b1 || p0_rdata !== exp_word(i - 1)) begin
                    errors++;
                    $display("FAIL stream_data[%0d]: rvalid=%b rdata=%h required 1 %h",
                             i, p0_rvalid, p0_rdata, exp_word(i - 1));
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        set_p1(1'b1, 1'b1, 17'h5, 32'h1);
        #1;
        checks++;
        if (p1_gnt !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 17'h5) begin
            errors++;
            $display("FAIL b2b_st: gnt=%b we=%b addr=%h required 1 1 5", p1_gnt, ram_we, ram_addr);
        end
        next_cycle();
        set_p1(1'b0, 1'b0, '0, '0);
        set_p0(1'b1, 1'b0, 17'h5, '0);
        #1;
        checks++;
        if (p0_gnt !== 1'b1 || p1_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ld: gnt=%b p1_rvalid=%b required 1 0", p0_gnt, p1_rvalid);
        end
        next_cycle();
        set_p0(1'b0, 1'b0, '0, '0);
        checks++;
        if (p0_rvalid !== 1'b1 || p0_rdata !== 32'h1) begin
            errors++;
            $display("FAIL b2b_data: rvalid=%b rdata=%h required 1 00000001", p0_rvalid, p0_rdata);
        end
        next_cycle();
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = exp_word(i);
        ram_dout = '0;
        test_reset();
        test_store_load();
        test_round_robin();
        test_out_of_range();
        test_reset_mid();
        test_stream();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
